// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: run-time loaded instruction array with a registered, stallable and flushable fetch port
module inst_mem_pipe #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4096,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_loaded,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_inst_valid,
    output logic              o_misaligned,
    output logic              o_out_of_range
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = ADDR_W - 2;

    typedef enum logic [1:0] {RESET_HOLD, LOAD, RUN} state_t;

    state_t            r_state, w_next;
    logic [AW-1:0]     r_wptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_inst;
    logic              r_valid, r_mis, r_oor;
    logic              w_ld_acc, w_ld_end, w_oor, w_mis;
    logic [IW-1:0]     w_idx;

    assign o_ld_ready     = r_state == LOAD;
    assign o_loaded       = r_state == RUN;
    assign o_inst         = r_inst;
    assign o_inst_valid   = r_valid;
    assign o_misaligned   = r_mis;
    assign o_out_of_range = r_oor;

    assign w_ld_acc = i_ld_valid && o_ld_ready;
    assign w_ld_end = w_ld_acc && (i_ld_last || r_wptr == AW'(DEPTH - 1));
    assign w_idx    = i_fetch_addr[ADDR_W-1:2];
    // one extra bit so DEPTH == 2^(ADDR_W-2) is representable
    assign w_oor    = {1'b0, w_idx} >= (IW + 1)'(DEPTH);
    assign w_mis    = |i_fetch_addr[1:0];

    always_comb begin
        w_next = r_state;
        if (r_state == RESET_HOLD)
            w_next = LOAD;
        else if (w_ld_end)
            w_next = RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RESET_HOLD;
            r_wptr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_acc)
                r_wptr <= r_wptr + AW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ld_acc)
            r_mem[r_wptr] <= i_ld_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || r_state != RUN) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_oor   <= 1'b0;
        end else if (!i_stall) begin
            r_inst  <= w_oor ? NOP_INST : r_mem[w_idx[AW-1:0]];
            r_valid <= 1'b1;
            r_mis   <= w_mis;
            r_oor   <= w_oor;
        end
    end
endmodule

// File: tb/tb_inst_mem_pipe.sv
// tb_inst_mem_pipe: randomized scenarios checked against a behavioural model of the instruction memory
module tb_inst_mem_pipe;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0, ld_last = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] ld_data = '0;
    logic [15:0] fetch_addr = '0;
    logic        ld_ready, loaded, inst_valid, mis, oor;
    logic [31:0] inst;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_phase = 0;
    int          m_wptr = 0;
    logic [31:0] m_inst = NOP;
    logic        m_valid = 1'b0, m_mis = 1'b0, m_oor = 1'b0;
    logic [31:0] full_q [$];

    inst_mem_pipe dut (
        .i_clk(clk), .i_rst(rst),
        .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last),
        .o_ld_ready(ld_ready), .o_loaded(loaded),
        .i_fetch_addr(fetch_addr), .i_stall(stall), .i_flush(flush),
        .o_inst(inst), .o_inst_valid(inst_valid),
        .o_misaligned(mis), .o_out_of_range(oor)
    );

    always #5 clk = ~clk;

    // model phases: 0 hold after reset, 1 loading, 2 running
    task automatic cyc();
        int idx;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_wptr = 0;
            m_inst = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (ld_valid) begin
                m_mem[m_wptr] = ld_data;
                if (ld_last || m_wptr == DEPTH - 1) m_phase = 2;
                m_wptr++;
            end
        end else if (flush) begin
            m_inst = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        end else if (!stall) begin
            idx = int'(fetch_addr) / 4;
            m_valid = 1;
            m_mis = fetch_addr % 4 != 0;
            m_oor = idx >= DEPTH;
            m_inst = m_oor ? NOP : m_mem[idx % DEPTH];
        end
        #1;
    endtask

    task automatic fetch(input logic [15:0] a, input logic st, input logic fl);
        fetch_addr = a; stall = st; flush = fl;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom;
            fetch(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if ({ld_ready, loaded, inst, inst_valid, mis, oor} !== {2'b00, NOP, 3'b000}) begin
                errors++;
                $display("FAIL reset got %h want %h", {ld_ready, loaded, inst, inst_valid, mis, oor}, {2'b00, NOP, 3'b000});
            end
        end
        rst = 0; ld_valid = 0;
        fetch(16'h0, 0, 0);
        checks++;
        if ({ld_ready, loaded, inst_valid} !== {m_phase == 1, m_phase == 2, 1'b0}) begin
            errors++;
            $display("FAIL reset_release got %b want %b", {ld_ready, loaded, inst_valid}, {m_phase == 1, m_phase == 2, 1'b0});
        end
    endtask

    task automatic test_load(input logic [31:0] words [$], input bit use_last, input bit gaps);
        int n = words.size();
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 2 * n + 20) begin
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_data = words[sent];
            ld_last = use_last && sent == n - 1;
            if (ld_valid && m_phase == 1) sent++;
            fetch(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
            checks++;
            if ({ld_ready, loaded, inst, inst_valid, mis, oor} !== {m_phase == 1, m_phase == 2, m_inst, m_valid, m_mis, m_oor}) begin
                errors++;
                $display("FAIL load word %0d got %h want %h", sent, {ld_ready, loaded, inst, inst_valid, mis, oor},
                         {m_phase == 1, m_phase == 2, m_inst, m_valid, m_mis, m_oor});
            end
        end
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL load_timeout got %0d words want %0d", sent, n);
        end
        ld_valid = 0; ld_last = 0; stall = 0; flush = 0;
    endtask

    task automatic test_load4();
        logic [31:0] w [$] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
        test_load(w, 1, 1);
        checks++;
        if ({ld_ready, loaded, inst_valid} !== 3'b010) begin
            errors++;
            $display("FAIL load4_done got %b want 010", {ld_ready, loaded, inst_valid});
        end
    endtask

    task automatic test_fetch_basic();
        logic [31:0] exp [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        for (int i = 0; i < 3; i++) begin
            fetch(16'(4 * i), 0, 0);
            checks++;
            if ({inst, inst_valid, mis, oor} !== {exp[i], 3'b100}) begin
                errors++;
                $display("FAIL fetch_%0d got %h want %h", i, {inst, inst_valid, mis, oor}, {exp[i], 3'b100});
            end
        end
    endtask

    task automatic test_stall();
        fetch(16'h4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            fetch(i == 0 ? 16'h4 : 16'h8, 1, 0);
            checks++;
            if ({inst, inst_valid} !== {32'h00A00113, 1'b1}) begin
                errors++;
                $display("FAIL stall_%0d got %h want %h", i, {inst, inst_valid}, {32'h00A00113, 1'b1});
            end
        end
        fetch(16'h8, 0, 0);
        checks++;
        if (inst !== 32'h002081B3) begin
            errors++;
            $display("FAIL stall_release got %h want 002081b3", inst);
        end
    endtask

    task automatic test_flush();
        fetch(16'h6, 1, 1);
        checks++;
        if ({inst, inst_valid, mis, oor} !== {NOP, 3'b000}) begin
            errors++;
            $display("FAIL flush got %h want %h", {inst, inst_valid, mis, oor}, {NOP, 3'b000});
        end
        fetch(16'h0, 0, 0);
        checks++;
        if ({inst, inst_valid} !== {32'h00500093, 1'b1}) begin
            errors++;
            $display("FAIL after_flush got %h want %h", {inst, inst_valid}, {32'h00500093, 1'b1});
        end
    endtask

    task automatic test_flags();
        fetch(16'h0006, 0, 0);
        checks++;
        if ({inst, inst_valid, mis, oor} !== {32'h00A00113, 3'b110}) begin
            errors++;
            $display("FAIL misaligned got %h want %h", {inst, inst_valid, mis, oor}, {32'h00A00113, 3'b110});
        end
        fetch(16'h4000, 0, 0);
        checks++;
        if ({inst, inst_valid, mis, oor} !== {NOP, 3'b101}) begin
            errors++;
            $display("FAIL out_of_range got %h want %h", {inst, inst_valid, mis, oor}, {NOP, 3'b101});
        end
    endtask

    task automatic test_random_fetch(input int n, input int lim);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, lim - 1) * 4);
                1: a = 16'($urandom_range(0, lim - 1) * 4 + $urandom_range(1, 3));
                2: a = 16'h4000 | 16'($urandom);
                default: a = 16'($urandom_range(lim - 1, 0) * 4 + $urandom_range(0, 3));
            endcase
            fetch(a, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            checks++;
            if ({inst, inst_valid, mis, oor} !== {m_inst, m_valid, m_mis, m_oor}) begin
                errors++;
                $display("FAIL random_fetch addr %h got %h want %h", a, {inst, inst_valid, mis, oor}, {m_inst, m_valid, m_mis, m_oor});
            end
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_full_load();
        rst = 1; cyc(); rst = 0;
        full_q.delete();
        for (int i = 0; i < DEPTH; i++) full_q.push_back($urandom);
        test_load(full_q, 0, 1);
        checks++;
        if ({ld_ready, loaded} !== 2'b01) begin
            errors++;
            $display("FAIL full_load_done got %b want 01", {ld_ready, loaded});
        end
        ld_valid = 1; ld_data = ~full_q[0]; ld_last = 1;
        fetch(16'h0, 0, 0);
        fetch(16'h0, 0, 0);
        ld_valid = 0; ld_last = 0;
        checks++;
        if ({ld_ready, inst, inst_valid} !== {1'b0, full_q[0], 1'b1}) begin
            errors++;
            $display("FAIL ignore_extra got %h want %h", {ld_ready, inst, inst_valid}, {1'b0, full_q[0], 1'b1});
        end
        fetch(16'((DEPTH - 1) * 4), 0, 0);
        checks++;
        if (inst !== full_q[DEPTH - 1]) begin
            errors++;
            $display("FAIL last_word got %h want %h", inst, full_q[DEPTH - 1]);
        end
        test_random_fetch(300, DEPTH);
    endtask

    task automatic test_reset_midload();
        logic [31:0] a [$] = '{$urandom, $urandom};
        logic [31:0] b [$] = '{$urandom, $urandom};
        rst = 1; cyc(); rst = 0;
        test_load(a, 0, 1);
        rst = 1; cyc(); rst = 0;
        checks++;
        if ({ld_ready, loaded, inst_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midload_reset got %b want 000", {ld_ready, loaded, inst_valid});
        end
        test_load(b, 1, 1);
        for (int i = 0; i < 3; i++) begin
            fetch(16'(4 * i), 0, 0);
            checks++;
            if ({inst, inst_valid} !== {i < 2 ? b[i] : full_q[2], 1'b1}) begin
                errors++;
                $display("FAIL reload_%0d got %h want %h", i, {inst, inst_valid}, {i < 2 ? b[i] : full_q[2], 1'b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_load4();
        test_fetch_basic();
        test_stall();
        test_flush();
        test_flags();
        test_random_fetch(200, 4);
        test_full_load();
        test_reset_midload();
        test_random_fetch(200, DEPTH);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
